xspi_req_arb2: RTL and testbench

Two-requester, burst-aware round-robin arbiter for the XSPI AXI slave. It shares one downstream command/data path between two upstream sources: requester 0 (write channel) and requester 1 (read channel). It drives the select of the 2:1 data mux and holds a grant for a whole burst. A one-deep registered output stage with valid/ready handshake sits between the mux and the downstream XSPI controller interface.

---
 rtl/xspi_req_arb2.sv | 167 ++++++++++++++++
 tb/tb_xspi_req_arb2.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xspi_req_arb2.sv
// xspi_req_arb2: two-requester, burst-locking round-robin arbiter with a
// one-deep registered valid/ready output stage toward the XSPI controller.
// Requester 0 is the write channel, requester 1 the read channel.
module xspi_req_arb2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d0_valid,
    input  logic [WIDTH-1:0] d0_data,
    input  logic             d0_last,
    output logic             d0_ready,
    input  logic             d1_valid,
    input  logic [WIDTH-1:0] d1_data,
    input  logic             d1_last,
    output logic             d1_ready,
    output logic             z_valid,
    output logic [WIDTH-1:0] z_data,
    output logic             z_last,
    output logic             z_src,
    input  logic             z_ready,
    output logic             sel,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             pri_r;
    logic             z_valid_r;
    logic [WIDTH-1:0] z_data_r;
    logic             z_last_r;
    logic             z_src_r;

    logic             win_s;      // requester currently selected by the mux
    logic             gnt_s;      // some requester holds the selection
    logic             ld_s;       // output stage can take a beat this cycle
    logic             acc_s;      // a beat is transferred this cycle
    logic             acc_src_s;
    logic             acc_last_s;
    logic [WIDTH-1:0] acc_data_s;

    // Output stage is free when empty or when its beat leaves this cycle.
    assign ld_s = !z_valid_r || z_ready;

    // Winner selection: round-robin in IDLE, locked to the owner during a burst.
    always_comb begin
        win_s = 1'b0;
        gnt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (d0_valid && d1_valid) begin
                    win_s = pri_r;
                    gnt_s = 1'b1;
                end else if (d1_valid) begin
                    win_s = 1'b1;
                    gnt_s = 1'b1;
                end else if (d0_valid) begin
                    win_s = 1'b0;
                    gnt_s = 1'b1;
                end else begin
                    win_s = 1'b0;
                    gnt_s = 1'b0;
                end
            end
            GNT0: begin
                win_s = 1'b0;
                gnt_s = 1'b1;
            end
            GNT1: begin
                win_s = 1'b1;
                gnt_s = 1'b1;
            end
            default: begin
                win_s = 1'b0;
                gnt_s = 1'b0;
            end
        endcase
    end

    assign d0_ready = ld_s && gnt_s && !win_s && d0_valid;
    assign d1_ready = ld_s && gnt_s &&  win_s && d1_valid;

    assign acc_s      = d0_ready || d1_ready;
    assign acc_src_s  = d1_ready;
    assign acc_last_s = d1_ready ? d1_last : d0_last;
    assign acc_data_s = d1_ready ? d1_data : d0_data;

    // Next-state: lock on a multi-beat burst start, release on its last beat.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (acc_s && !acc_last_s) begin
                    state_nxt_s = acc_src_s ? GNT1 : GNT0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GNT0: begin
                if (acc_s && acc_last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GNT0;
                end
            end
            GNT1: begin
                if (acc_s && acc_last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GNT1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Priority pointer: the first beat of a burst hands preference to the other side.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pri_r <= 1'b0;
        end else if (acc_s && (state_r == IDLE)) begin
            pri_r <= !acc_src_s;
        end
    end

    // Output register: load on accept, drain on downstream handshake, else hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z_valid_r <= 1'b0;
            z_data_r  <= {WIDTH{1'b0}};
            z_last_r  <= 1'b0;
            z_src_r   <= 1'b0;
        end else if (acc_s) begin
            z_valid_r <= 1'b1;
            z_data_r  <= acc_data_s;
            z_last_r  <= acc_last_s;
            z_src_r   <= acc_src_s;
        end else if (z_valid_r && z_ready) begin
            z_valid_r <= 1'b0;
        end
    end

    assign z_valid = z_valid_r;
    assign z_data  = z_data_r;
    assign z_last  = z_last_r;
    assign z_src   = z_src_r;
    assign sel     = win_s;
    assign busy    = (state_r != IDLE);

endmodule

// File: tb/tb_xspi_req_arb2.sv
// Scoreboard bench for xspi_req_arb2: stimulus pushes hand-ordered expected
// beats; a monitor pops and compares every beat the DUT hands downstream.
module tb_xspi_req_arb2;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } beat_t;

    typedef struct packed {
        logic        src;
        logic        last;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        d0_valid, d0_last, d0_ready;
    logic [31:0] d0_data;
    logic        d1_valid, d1_last, d1_ready;
    logic [31:0] d1_data;
    logic        z_valid, z_last, z_src, z_ready;
    logic [31:0] z_data;
    logic        sel, busy;

    beat_t q0[$];
    beat_t q1[$];
    exp_t  exp_q[$];
    logic  hold0, hold1;
    logic  a0, a1, r0s, r1s;
    int    total, bad;

    xspi_req_arb2 #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .d0_valid(d0_valid), .d0_data(d0_data), .d0_last(d0_last), .d0_ready(d0_ready),
        .d1_valid(d1_valid), .d1_data(d1_data), .d1_last(d1_last), .d1_ready(d1_ready),
        .z_valid(z_valid), .z_data(z_data), .z_last(z_last), .z_src(z_src), .z_ready(z_ready),
        .sel(sel), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_w(input string name, input logic [33:0] act, input logic [33:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: every beat taken downstream must match the next expected one.
    always @(negedge clk) begin
        if (!reset && z_valid && z_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard: unexpected beat src=%0b data=%h", z_src, z_data);
            end else begin
                chk_w("scoreboard", {z_src, z_last, z_data}, exp_q.pop_front());
            end
        end
    end

    task automatic drive();
        d0_valid = (q0.size() > 0) && !hold0;
        d0_data  = (q0.size() > 0) ? q0[0].data : 32'h0;
        d0_last  = (q0.size() > 0) ? q0[0].last : 1'b0;
        d1_valid = (q1.size() > 0) && !hold1;
        d1_data  = (q1.size() > 0) ? q1[0].data : 32'h0;
        d1_last  = (q1.size() > 0) ? q1[0].last : 1'b0;
    endtask

    task automatic add(input int src, input logic [31:0] data, input logic last);
        beat_t b;
        b.last = last;
        b.data = data;
        if (src == 0) q0.push_back(b);
        else          q1.push_back(b);
    endtask

    task automatic expect_beat(input logic src, input logic [31:0] data, input logic last);
        exp_t e;
        e.src  = src;
        e.last = last;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // One clock: sample handshakes mid-cycle, then advance sources after the edge.
    task automatic step();
        @(negedge clk);
        r0s = d0_ready;
        r1s = d1_ready;
        a0  = d0_valid && d0_ready;
        a1  = d1_valid && d1_ready;
        if (r0s && r1s) chk1("both_ready", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        if (a0) void'(q0.pop_front());
        if (a1) void'(q1.pop_front());
        drive();
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0) break;
            step();
        end
        chk1("drain_empty", (exp_q.size() == 0) && (q0.size() == 0) && (q1.size() == 0), 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        hold0   = 1'b0;
        hold1   = 1'b0;
        z_ready = 1'b1;
        reset   = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_z_valid", z_valid, 1'b0);
        chk_w("rst_z_regs", {z_src, z_last, z_data}, 34'h0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_sel", sel, 1'b0);
        chk1("rst_rdy", d0_ready | d1_ready, 1'b0);
        reset = 1'b0;

        // d0 burst of 4 beats, accepted back-to-back.
        for (int k = 0; k < 4; k++) begin
            add(0, 32'hA0 + 32'(k), k == 3);
            expect_beat(1'b0, 32'hA0 + 32'(k), k == 3);
        end
        drive();
        for (int k = 0; k < 4; k++) begin
            step();
            chk1("p1_accept", a0, 1'b1);
            chk1("p1_busy", busy, k < 3);
        end
        drain();

        // Both valid from reset, 2-beat bursts x3: grant order 0,1,0,1,0,1.
        do_reset();
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 2; k++) begin
                add(0, 32'hB0 + 32'(2 * b + k), k == 1);
                add(1, 32'hC0 + 32'(2 * b + k), k == 1);
            end
        end
        for (int b = 0; b < 3; b++) begin
            expect_beat(1'b0, 32'hB0 + 32'(2 * b), 1'b0);
            expect_beat(1'b0, 32'hB1 + 32'(2 * b), 1'b1);
            expect_beat(1'b1, 32'hC0 + 32'(2 * b), 1'b0);
            expect_beat(1'b1, 32'hC1 + 32'(2 * b), 1'b1);
        end
        drive();
        for (int i = 0; i < 12; i++) begin
            step();
            chk1("p2_no_gap", a0 | a1, 1'b1);
            chk1("p2_src", a1, ((i / 2) % 2) == 1);
            if (((i / 2) % 2) == 0) chk1("p2_d1_rdy_in_d0", r1s, 1'b0);
        end
        drain();

        // Backpressure: z_ready low for 5 cycles mid-burst.
        for (int k = 0; k < 4; k++) begin
            add(0, 32'hD0 + 32'(k), k == 3);
            expect_beat(1'b0, 32'hD0 + 32'(k), k == 3);
        end
        drive();
        step();
        step();
        z_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk1("p3_ready_low", r0s | r1s, 1'b0);
            chk1("p3_valid_hold", z_valid, 1'b1);
            chk_w("p3_data_hold", {z_src, z_last, z_data}, {1'b0, 1'b0, 32'hD1});
        end
        z_ready = 1'b1;
        step();
        chk1("p3_resume", a0, 1'b1);
        drain();

        // Single-beat bursts, both valid: pointer is at 1 after the d0 burst.
        for (int k = 0; k < 3; k++) begin
            add(0, 32'hE0 + 32'(k), 1'b1);
            add(1, 32'hF0 + 32'(k), 1'b1);
            expect_beat(1'b1, 32'hF0 + 32'(k), 1'b1);
            expect_beat(1'b0, 32'hE0 + 32'(k), 1'b1);
        end
        drive();
        for (int i = 0; i < 6; i++) begin
            step();
            chk1("p4_alt", a1, (i % 2) == 0);
            chk1("p4_no_gap", a0 | a1, 1'b1);
            chk1("p4_busy", busy, 1'b0);
        end
        drain();

        // d1 burst with a 2-cycle valid gap while d0 waits.
        add(1, 32'h60, 1'b0);
        add(1, 32'h61, 1'b0);
        add(1, 32'h62, 1'b1);
        add(0, 32'h70, 1'b0);
        add(0, 32'h71, 1'b1);
        expect_beat(1'b1, 32'h60, 1'b0);
        expect_beat(1'b1, 32'h61, 1'b0);
        expect_beat(1'b1, 32'h62, 1'b1);
        expect_beat(1'b0, 32'h70, 1'b0);
        expect_beat(1'b0, 32'h71, 1'b1);
        drive();
        step();
        chk1("p5_first_d1", a1, 1'b1);
        hold1 = 1'b1;
        drive();
        for (int i = 0; i < 2; i++) begin
            step();
            chk1("p5_d0_blocked", r0s, 1'b0);
            chk1("p5_busy", busy, 1'b1);
        end
        hold1 = 1'b0;
        drive();
        step();
        chk1("p5_d1_beat2", a1, 1'b1);
        step();
        chk1("p5_d1_last", a1, 1'b1);
        step();
        chk1("p5_d0_next", a0, 1'b1);
        drain();

        // Reset while GNT1 holds a beat in the output register.
        add(1, 32'h90, 1'b0);
        add(1, 32'h91, 1'b0);
        add(1, 32'h92, 1'b1);
        drive();
        step();
        z_ready = 1'b0;
        chk1("p6_pre_busy", busy, 1'b1);
        chk1("p6_pre_valid", z_valid, 1'b1);
        reset = 1'b1;
        q0.delete();
        q1.delete();
        drive();
        #1;
        chk1("p6_rst_valid", z_valid, 1'b0);
        chk1("p6_rst_busy", busy, 1'b0);
        chk1("p6_rst_sel", sel, 1'b0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        z_ready = 1'b1;
        add(0, 32'h50, 1'b1);
        add(1, 32'h51, 1'b1);
        expect_beat(1'b0, 32'h50, 1'b1);
        expect_beat(1'b1, 32'h51, 1'b1);
        drive();
        step();
        chk1("p6_first_d0", a0, 1'b1);
        step();
        chk1("p6_then_d1", a1, 1'b1);
        drain();

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
